// File: rtl/stream_arbiter_unit.sv
// Per-output round-robin packet arbiter: each output locks onto one input stream until that
// stream's last beat. Defining STREAM_ARB_TIMEOUT_EN adds a per-output stall timeout.
module stream_arbiter_unit #(
  parameter  int S_DATA_COUNT   = 2,
  parameter  int M_DATA_COUNT   = 3,
  parameter  int TIMEOUT_CYCLES = 16,
  localparam int T_ID___WIDTH   = $clog2(S_DATA_COUNT),
  localparam int T_DEST_WIDTH   = $clog2(M_DATA_COUNT)
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0]  s_dest_i,
  input  logic [S_DATA_COUNT-1:0]                    s_valid_i,
  input  logic [S_DATA_COUNT-1:0]                    s_last_i,
  input  logic [M_DATA_COUNT-1:0]                    m_ready_i,
  output logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0]  grant_o,
  output logic [M_DATA_COUNT-1:0]                    arbiter_ready_o,
  output logic [M_DATA_COUNT-1:0]                    timeout_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  if (S_DATA_COUNT < 2) begin : g_bad_s_count
    $error("stream_arbiter_unit: S_DATA_COUNT must be >= 2");
  end
  if (M_DATA_COUNT < 2) begin : g_bad_m_count
    $error("stream_arbiter_unit: M_DATA_COUNT must be >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("stream_arbiter_unit: TIMEOUT_CYCLES must be >= 1");
  end

  // Input index after idx, wrapping from the last input back to input 0.
  function automatic logic [T_ID___WIDTH-1:0] wrap_inc(input logic [T_ID___WIDTH-1:0] idx);
    return (idx == T_ID___WIDTH'(S_DATA_COUNT - 1)) ? '0 : idx + 1'b1;
  endfunction

  // First requester at or above ptr, wrapping; only meaningful when req != 0.
  function automatic logic [T_ID___WIDTH-1:0] rr_pick(
    input logic [S_DATA_COUNT-1:0] req,
    input logic [T_ID___WIDTH-1:0] ptr
  );
    logic [T_ID___WIDTH-1:0] idx;
    logic [T_ID___WIDTH-1:0] pick;
    logic                    found;
    idx   = ptr;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < S_DATA_COUNT; k++) begin
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
      idx = wrap_inc(idx);
    end
    return pick;
  endfunction

`ifndef STREAM_ARB_TIMEOUT_EN
  assign timeout_o = '0;
`endif

  for (genvar i = 0; i < M_DATA_COUNT; i++) begin : g_out
    localparam logic [T_DEST_WIDTH-1:0] OUT_IDX = T_DEST_WIDTH'(i);

    state_t                  state;
    logic [T_ID___WIDTH-1:0] grant_q;
    logic [T_ID___WIDTH-1:0] rr_ptr;
    logic [T_ID___WIDTH-1:0] pick;
    logic [S_DATA_COUNT-1:0] req;
    logic                    beat;
    logic                    last_beat;

    // Out-of-range destinations never match any OUT_IDX, so they never request.
    for (genvar j = 0; j < S_DATA_COUNT; j++) begin : g_req
      assign req[j] = s_valid_i[j] && (s_dest_i[j] == OUT_IDX);
    end

    assign pick      = rr_pick(req, rr_ptr);
    assign beat      = (state == LOCKED) && s_valid_i[grant_q] && m_ready_i[i];
    assign last_beat = beat && s_last_i[grant_q];

`ifdef STREAM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] stall_cnt;
    logic             timeout_q;

    always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments throughout sequential blocks, so every flop
      // samples the pre-edge values of its neighbours regardless of statement order.
      if (rst_i) begin
        // NOTE: grant and pointer flops are reset explicitly: grant_o must read 0 and the
        // first arbitration after reset must start from input 0.
        state     <= IDLE;
        grant_q   <= '0;
        rr_ptr    <= '0;
        stall_cnt <= '0;
        timeout_q <= 1'b0;
      end else begin
        timeout_q <= 1'b0;
        case (state)
          IDLE: begin
            if (|req) begin
              grant_q   <= pick;
              rr_ptr    <= wrap_inc(pick);
              stall_cnt <= '0;
              state     <= LOCKED;
            end
          end
          LOCKED: begin
            // The pulse fires as the count reaches the limit; the release follows one edge later.
            if (stall_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
              state <= IDLE;
            end else if (beat) begin
              stall_cnt <= '0;
              if (last_beat) state <= IDLE;
            end else begin
              stall_cnt <= stall_cnt + 1'b1;
              if (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) timeout_q <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end

    assign timeout_o[i] = timeout_q;
`else
    always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments throughout sequential blocks, so every flop
      // samples the pre-edge values of its neighbours regardless of statement order.
      if (rst_i) begin
        // NOTE: grant and pointer flops are reset explicitly: grant_o must read 0 and the
        // first arbitration after reset must start from input 0.
        state   <= IDLE;
        grant_q <= '0;
        rr_ptr  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (|req) begin
              grant_q <= pick;
              rr_ptr  <= wrap_inc(pick);
              state   <= LOCKED;
            end
          end
          LOCKED: begin
            if (last_beat) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
`endif

    assign grant_o[i]         = grant_q;
    assign arbiter_ready_o[i] = (state == LOCKED);
  end

endmodule

// File: tb/tb_stream_arbiter_unit.sv
// Self-checking bench for stream_arbiter_unit: directed scenarios plus randomized packet
// traffic, scored against a queue of per-cycle expectations from an abstract model.
module tb_stream_arbiter_unit;

  localparam int S  = 2;
  localparam int M  = 3;
  localparam int TO = 4;
  localparam int IW = $clog2(S);
  localparam int DW = $clog2(M);
`ifdef STREAM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [M-1:0]         ready;
    logic [M-1:0]         tmo;
    logic [M-1:0][IW-1:0] grant;
  } snap_t;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic [S-1:0][DW-1:0] s_dest;
  logic [S-1:0]         s_valid;
  logic [S-1:0]         s_last;
  logic [M-1:0]         m_ready;
  logic [M-1:0][IW-1:0] grant;
  logic [M-1:0]         arb_ready;
  logic [M-1:0]         timeout;

  stream_arbiter_unit #(
    .S_DATA_COUNT  (S),
    .M_DATA_COUNT  (M),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .s_dest_i       (s_dest),
    .s_valid_i      (s_valid),
    .s_last_i       (s_last),
    .m_ready_i      (m_ready),
    .grant_o        (grant),
    .arbiter_ready_o(arb_ready),
    .timeout_o      (timeout)
  );

  always #5 clk_i = ~clk_i;

  int    n_tests = 0;
  int    n_fail  = 0;
  snap_t exp_q[$];

  // Reference model: owner = input holding output o (-1 when free); stall = cycles
  // since the last beat of the current lock.
  int owner[M];
  int gnt[M];
  int ptr[M];
  int stall[M];
  bit beat_in[S];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    snap_t s;
    int    g;
    bit    found;
    bit    beat;
    s = '0;
    for (int j = 0; j < S; j++) beat_in[j] = 1'b0;
    for (int o = 0; o < M; o++) begin
      if (rst_i) begin
        owner[o] = -1;
        gnt[o]   = 0;
        ptr[o]   = 0;
        stall[o] = 0;
      end else if (owner[o] < 0) begin
        found = 1'b0;
        for (int k = 0; k < S; k++) begin
          g = (ptr[o] + k) % S;
          if (!found && s_valid[g] && int'(s_dest[g]) == o) begin
            found    = 1'b1;
            owner[o] = g;
            gnt[o]   = g;
            ptr[o]   = (g + 1) % S;
            stall[o] = 0;
          end
        end
      end else begin
        g = owner[o];
        if (TO_EN && stall[o] >= TO) begin
          owner[o] = -1;
        end else begin
          beat = s_valid[g] && m_ready[o];
          if (beat) begin
            beat_in[g] = 1'b1;
            stall[o]   = 0;
            if (s_last[g]) owner[o] = -1;
          end else begin
            stall[o]++;
            if (TO_EN && stall[o] == TO) s.tmo[o] = 1'b1;
          end
        end
      end
      s.ready[o] = (owner[o] >= 0);
      s.grant[o] = IW'(gnt[o]);
    end
    exp_q.push_back(s);
  endtask

  // Apply one cycle of inputs, record the expected post-edge outputs, move to the next negedge.
  task automatic drive(input logic rs, input logic [S-1:0] v, input logic [S-1:0][DW-1:0] d,
                       input logic [S-1:0] l, input logic [M-1:0] r);
    rst_i   = rs;
    s_valid = v;
    s_dest  = d;
    s_last  = l;
    m_ready = r;
    model_step();
    @(negedge clk_i);
  endtask

  // Monitor: compares every post-edge output snapshot against the scoreboard.
  initial begin
    snap_t s;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        check("mon_ready", arb_ready, s.ready);
        check("mon_grant", grant, s.grant);
        check("mon_timeout", timeout, s.tmo);
      end
    end
  end

  int c_last[13] = '{0, 0, 0, 1, 0, 0, 0, 2, 0, 0, 0, 1, 0};
  int c_rdy [13] = '{1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 0, 0};
  int c_gnt [13] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0};

  initial begin
    int                   src_dest[S];
    int                   src_left[S];
    logic [S-1:0]         v;
    logic [S-1:0]         l;
    logic [S-1:0][DW-1:0] d;
    logic [M-1:0]         r;
    logic                 rs;

    for (int o = 0; o < M; o++) begin
      owner[o] = -1;
      gnt[o]   = 0;
      ptr[o]   = 0;
      stall[o] = 0;
    end

    // Reset with every input requesting.
    drive(1'b1, 2'b11, {2'd0, 2'd0}, 2'b00, 3'b111);
    drive(1'b1, 2'b11, {2'd0, 2'd0}, 2'b00, 3'b111);
    check("rst_ready", arb_ready, 3'b000);
    check("rst_grant", grant, 0);
    check("rst_timeout", timeout, 3'b000);

    // Parallel locks on different outputs, each a single-beat packet.
    drive(1'b0, 2'b11, {2'd1, 2'd0}, 2'b11, 3'b111);
    check("par_ready", arb_ready, 3'b011);
    check("par_grant0", grant[0], 0);
    check("par_grant1", grant[1], 1);
    drive(1'b0, 2'b11, {2'd1, 2'd0}, 2'b11, 3'b111);
    check("single_beat_release", arb_ready, 3'b000);

    // Contention on output 2: 3-beat packets, grants 0,1,0 with a bubble between locks.
    for (int k = 0; k < 13; k++) begin
      drive(1'b0, (k == 12) ? 2'b00 : 2'b11, {2'd2, 2'd2}, S'(c_last[k]), 3'b111);
      check($sformatf("cont_ready2_%0d", k), arb_ready[2], c_rdy[k]);
      check($sformatf("cont_grant2_%0d", k), grant[2], c_gnt[k]);
    end

    // Backpressure on output 1.
    drive(1'b0, 2'b10, {2'd1, 2'd0}, 2'b10, 3'b111);
    check("bp_lock", arb_ready[1], 1'b1);
    check("bp_grant", grant[1], 1);
`ifdef STREAM_ARB_TIMEOUT_EN
    for (int k = 0; k < 3; k++) begin
`else
    for (int k = 0; k < 5; k++) begin
`endif
      drive(1'b0, 2'b10, {2'd1, 2'd0}, 2'b10, 3'b101);
      check($sformatf("bp_hold_%0d", k), arb_ready[1], 1'b1);
    end
    drive(1'b0, 2'b10, {2'd1, 2'd0}, 2'b10, 3'b111);
    check("bp_release", arb_ready[1], 1'b0);

    // Stalled lock on output 0.
    drive(1'b0, 2'b01, {2'd0, 2'd0}, 2'b00, 3'b111);
    check("to_lock", arb_ready[0], 1'b1);
    check("to_grant", grant[0], 0);
`ifdef STREAM_ARB_TIMEOUT_EN
    for (int k = 1; k <= 3; k++) begin
      drive(1'b0, 2'b00, {2'd0, 2'd0}, 2'b00, 3'b111);
      check($sformatf("to_wait_%0d", k), timeout, 3'b000);
    end
    drive(1'b0, 2'b00, {2'd0, 2'd0}, 2'b00, 3'b111);
    check("to_pulse", timeout, 3'b001);
    check("to_pulse_ready", arb_ready[0], 1'b1);
    drive(1'b0, 2'b00, {2'd0, 2'd0}, 2'b00, 3'b111);
    check("to_released", arb_ready[0], 1'b0);
    check("to_pulse_end", timeout, 3'b000);
`else
    for (int k = 1; k <= 8; k++) begin
      drive(1'b0, 2'b00, {2'd0, 2'd0}, 2'b00, 3'b111);
      check($sformatf("nto_hold_%0d", k), arb_ready[0], 1'b1);
      check($sformatf("nto_timeout_%0d", k), timeout, 3'b000);
    end
    drive(1'b0, 2'b01, {2'd0, 2'd0}, 2'b01, 3'b111);
    check("nto_release", arb_ready[0], 1'b0);
`endif

    // Reset in the middle of a packet on output 2 (pointer was at input 1 beforehand).
    drive(1'b0, 2'b01, {2'd2, 2'd2}, 2'b00, 3'b111);
    check("mid_lock", arb_ready[2], 1'b1);
    check("mid_grant", grant[2], 0);
    drive(1'b0, 2'b01, {2'd2, 2'd2}, 2'b00, 3'b111);
    drive(1'b1, 2'b01, {2'd2, 2'd2}, 2'b00, 3'b111);
    check("mid_rst_ready", arb_ready, 3'b000);
    check("mid_rst_grant", grant, 0);
    drive(1'b0, 2'b11, {2'd2, 2'd2}, 2'b00, 3'b111);
    check("mid_regrant_ready", arb_ready[2], 1'b1);
    check("mid_regrant_ptr0", grant[2], 0);

    // Randomized packet traffic, including unroutable destinations and occasional reset.
    src_dest[0] = 2;
    src_left[0] = 4;
    src_dest[1] = 2;
    src_left[1] = 3;
    for (int c = 0; c < 1500; c++) begin
      for (int j = 0; j < S; j++) begin
        if (src_left[j] == 0 || src_dest[j] >= M) begin
          src_dest[j] = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, M - 1));
          src_left[j] = int'($urandom_range(1, 4));
        end
        v[j] = ($urandom_range(0, 3) != 0);
        l[j] = (src_left[j] == 1);
        d[j] = DW'(src_dest[j]);
      end
      r  = M'($urandom);
      rs = ($urandom_range(0, 149) == 0);
      drive(rs, v, d, l, r);
      for (int j = 0; j < S; j++) begin
        if (beat_in[j]) src_left[j]--;
        if (src_dest[j] >= M) src_left[j] = 0;
      end
    end

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk_i);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
